// File: rtl/cpu_isa_pkg.sv
// VeriRISC ISA constants, trace FSM state encoding and trace-entry field layout
// shared between the trace buffer and anything that decodes its entries.
package cpu_isa_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    // Field widths of one trace entry {pc, opcode, data, addr}, MSB to LSB
    localparam int PC_W   = 5;
    localparam int OP_W   = 3;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    localparam int ADDR_LSB = 0;
    localparam int DATA_LSB = ADDR_LSB + ADDR_W;
    localparam int OP_LSB   = DATA_LSB + DATA_W;
    localparam int PC_LSB   = OP_LSB + OP_W;
    localparam int ENTRY_W  = PC_LSB + PC_W;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one write port and one registered read port. A read and a
// write to the same slot in the same cycle return the old contents.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 21,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write the new entry and capture the old contents of the read slot on the same edge
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture for the VeriRISC CPU: circular buffer of retired
// instructions with opcode trigger + post-trigger count, halt-edge stop and
// indexed readback relative to the oldest valid entry.
module cpu_trace_buffer
    import cpu_isa_pkg::*;
#(
    parameter int PC_WIDTH   = PC_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int OP_WIDTH   = OP_W,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int FILL_W    = IDX_W + 1,
    localparam int ENT_W     = PC_WIDTH + OP_WIDTH + DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  retire,
    input  logic [PC_WIDTH-1:0]   pc_addr,
    input  logic [OP_WIDTH-1:0]   opcode,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] ir_addr,
    input  logic                  halt,
    input  logic                  arm,
    input  logic                  trig_en,
    input  logic [OP_WIDTH-1:0]   trig_op,
    input  logic [FILL_W-1:0]     post_count,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [ENT_W-1:0]      rd_entry,
    output logic                  rd_err,
    output logic [FILL_W-1:0]     entry_count,
    output logic [IDX_W-1:0]      trig_pos,
    output logic [1:0]            state_o,
    output logic                  triggered,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    trace_state_e         state_q, state_d;
    logic [IDX_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]    entry_count_q, entry_count_d;
    logic [IDX_W-1:0]     trig_slot_q, trig_slot_d;
    logic                 trig_evicted_q, trig_evicted_d;
    logic [FILL_W-1:0]    post_left_q, post_left_d;
    logic                 triggered_q, triggered_d;
    logic                 halted_q, halted_d;
    logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_err_q, rd_err_d;
    logic                 halt_q;

    logic                 wr_en;
    logic                 halt_rise;
    logic                 buf_full;
    logic [IDX_W-1:0]     oldest;
    logic [IDX_W-1:0]     rd_addr;
    logic [ENT_W-1:0]     ram_rdata;

    assign halt_rise = halt && !halt_q;
    assign buf_full  = (entry_count_q == FILL_W'(DEPTH));
    assign oldest    = buf_full ? wr_ptr_q : '0;
    assign rd_addr   = oldest + rd_idx;

    // Capture FSM: arming, recording, trigger/post-count bookkeeping, halt stop and readback request
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        entry_count_d  = entry_count_q;
        trig_slot_d    = trig_slot_q;
        trig_evicted_d = trig_evicted_q;
        post_left_d    = post_left_q;
        triggered_d    = triggered_q;
        halted_d       = halted_q;
        instr_count_d  = instr_count_q;
        wr_en          = 1'b0;
        rd_valid_d     = rd_en;
        rd_err_d       = rd_en && ({1'b0, rd_idx} >= entry_count_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d        = ST_ARMED;
                    wr_ptr_d       = '0;
                    entry_count_d  = '0;
                    trig_slot_d    = '0;
                    trig_evicted_d = 1'b0;
                    post_left_d    = '0;
                    triggered_d    = 1'b0;
                    halted_d       = 1'b0;
                    instr_count_d  = '0;
                end
            end
            ST_ARMED, ST_POST: begin
                if (retire) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + IDX_W'(1);
                    if (!buf_full) begin
                        entry_count_d = entry_count_q + FILL_W'(1);
                    end
                    if (instr_count_q != '1) begin
                        instr_count_d = instr_count_q + CNT_WIDTH'(1);
                    end
                    if (state_q == ST_ARMED) begin
                        if (trig_en && (opcode == trig_op)) begin
                            triggered_d = 1'b1;
                            trig_slot_d = wr_ptr_q;
                            post_left_d = post_count;
                            state_d     = (post_count == '0) ? ST_DONE : ST_POST;
                        end
                    end else begin
                        if (wr_ptr_q == trig_slot_q) begin
                            trig_evicted_d = 1'b1;
                        end
                        post_left_d = post_left_q - FILL_W'(1);
                        if (post_left_q == FILL_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                if (halt_rise) begin
                    state_d  = ST_DONE;
                    halted_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset wins over everything and drops any pending readback
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            entry_count_q  <= '0;
            trig_slot_q    <= '0;
            trig_evicted_q <= 1'b0;
            post_left_q    <= '0;
            triggered_q    <= 1'b0;
            halted_q       <= 1'b0;
            instr_count_q  <= '0;
            rd_valid_q     <= 1'b0;
            rd_err_q       <= 1'b0;
            halt_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            entry_count_q  <= entry_count_d;
            trig_slot_q    <= trig_slot_d;
            trig_evicted_q <= trig_evicted_d;
            post_left_q    <= post_left_d;
            triggered_q    <= triggered_d;
            halted_q       <= halted_d;
            instr_count_q  <= instr_count_d;
            rd_valid_q     <= rd_valid_d;
            rd_err_q       <= rd_err_d;
            halt_q         <= halt;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en && !rst),
        .wr_addr (wr_ptr_q),
        .wr_data ({pc_addr, opcode, data, ir_addr}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rdata)
    );

    assign rd_valid    = rd_valid_q;
    assign rd_err      = rd_err_q;
    assign rd_entry    = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;
    assign entry_count = entry_count_q;
    assign trig_pos    = (triggered_q && !trig_evicted_q) ? (trig_slot_q - oldest) : '0;
    assign state_o     = state_q;
    assign triggered   = triggered_q;
    assign halted      = halted_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: a reference list of recorded
// entries predicts every readback, expectations are queued at rd_en and
// popped when rd_valid comes back.
module tb_cpu_trace_buffer;
    import cpu_isa_pkg::*;

    logic        clock = 1'b0;
    logic        rst, retire, halt, arm, trig_en, rd_en;
    logic [4:0]  pc_addr, ir_addr, post_count, entry_count;
    logic [2:0]  opcode, trig_op;
    logic [7:0]  data;
    logic [3:0]  rd_idx, trig_pos;
    logic        rd_valid, rd_err, triggered, halted;
    logic [20:0] rd_entry;
    logic [1:0]  state_o;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [ENTRY_W-1:0] trace_q[$];
    logic [ENTRY_W:0]   exp_q[$];

    cpu_trace_buffer dut (
        .clock(clock), .rst(rst), .retire(retire), .pc_addr(pc_addr), .opcode(opcode),
        .data(data), .ir_addr(ir_addr), .halt(halt), .arm(arm), .trig_en(trig_en),
        .trig_op(trig_op), .post_count(post_count), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_entry(rd_entry), .rd_err(rd_err), .entry_count(entry_count),
        .trig_pos(trig_pos), .state_o(state_o), .triggered(triggered), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [ENTRY_W-1:0] mk_entry(int pc, int op);
        return {5'(pc), 3'(op), 8'(pc * 7 + 3), 5'(~pc)};
    endfunction

    function automatic logic [28:0] status_vec();
        return {state_o, entry_count, trig_pos, triggered, halted, instr_count};
    endfunction

    function automatic logic [28:0] exp_stat(int st, int cnt, int tp, bit trg, bit hlt, int ic);
        return {2'(st), 5'(cnt), 4'(tp), trg, hlt, 16'(ic)};
    endfunction

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        trace_q.delete();
    endtask

    task automatic do_retire(int pc, int op, bit rec, bit hlt);
        retire  = 1'b1;
        pc_addr = 5'(pc);
        opcode  = 3'(op);
        data    = 8'(pc * 7 + 3);
        ir_addr = 5'(~pc);
        halt    = hlt;
        step();
        retire  = 1'b0;
        if (rec) trace_q.push_back(mk_entry(pc, op));
    endtask

    task automatic push_read_exp(int idx);
        int n;
        int cnt;
        n   = trace_q.size();
        cnt = (n > 16) ? 16 : n;
        if (idx >= cnt) exp_q.push_back({1'b1, 21'h0});
        else            exp_q.push_back({1'b0, trace_q[n - cnt + idx]});
    endtask

    task automatic issue_read(int idx);
        push_read_exp(idx);
        rd_en  = 1'b1;
        rd_idx = 4'(idx);
        step();
        rd_en  = 1'b0;
    endtask

    task automatic test_reset();
        logic [28:0] es;
        rst = 1'b1;
        step();
        step();
        es = exp_stat(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL reset_status: got %h want %h", status_vec(), es);
        end
        n_cmp++;
        if ({rd_valid, rd_err, rd_entry} !== 23'h0) begin
            n_err++;
            $display("[TB] FAIL reset_read: got %h want 0", {rd_valid, rd_err, rd_entry});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_halt_stop();
        logic [28:0] es;
        logic [22:0] exp_r;
        trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 4; i++) do_retire(i, OP_LDA, 1'b1, 1'b0);
        do_retire(4, OP_HLT, 1'b1, 1'b1);
        es = exp_stat(ST_DONE, 5, 0, 0, 1, 5);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL halt_status: got %h want %h", status_vec(), es);
        end
        halt = 1'b0;
        do_retire(9, OP_ADD, 1'b0, 1'b0);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL done_frozen: got %h want %h", status_vec(), es);
        end
        issue_read(4);
        exp_r = {1'b1, exp_q.pop_front()};
        n_cmp++;
        if ({rd_valid, rd_err, rd_entry} !== exp_r) begin
            n_err++;
            $display("[TB] FAIL halt_read_hlt: got %h want %h", {rd_valid, rd_err, rd_entry}, exp_r);
        end
        issue_read(5);
        exp_r = {1'b1, exp_q.pop_front()};
        n_cmp++;
        if ({rd_valid, rd_err, rd_entry} !== exp_r) begin
            n_err++;
            $display("[TB] FAIL halt_read_oob: got %h want %h", {rd_valid, rd_err, rd_entry}, exp_r);
        end
    endtask

    task automatic test_wrap();
        logic [28:0] es;
        logic [22:0] exp_r;
        trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 20; i++) do_retire(i, i % 8, 1'b1, 1'b0);
        es = exp_stat(ST_ARMED, 16, 0, 0, 0, 20);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL wrap_status: got %h want %h", status_vec(), es);
        end
        for (int k = 0; k < 3; k++) begin
            issue_read((k == 0) ? 0 : ((k == 1) ? 15 : 7));
            exp_r = {1'b1, exp_q.pop_front()};
            n_cmp++;
            if ({rd_valid, rd_err, rd_entry} !== exp_r) begin
                n_err++;
                $display("[TB] FAIL wrap_read_%0d: got %h want %h", k, {rd_valid, rd_err, rd_entry}, exp_r);
            end
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        es = exp_stat(ST_DONE, 16, 0, 0, 1, 20);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL wrap_halt: got %h want %h", status_vec(), es);
        end
    endtask

    task automatic test_trigger();
        logic [28:0] es;
        logic [22:0] exp_r;
        trig_en    = 1'b1;
        trig_op    = OP_JMP;
        post_count = 5'd3;
        do_arm();
        for (int k = 1; k <= 10; k++) begin
            do_retire(k - 1, (k == 6) ? OP_JMP : OP_ADD, (k <= 9), 1'b0);
            if (k == 6) begin
                post_count = 5'd10;
                es = exp_stat(ST_POST, 6, 5, 1, 0, 6);
                n_cmp++;
                if (status_vec() !== es) begin
                    n_err++;
                    $display("[TB] FAIL trig_fire: got %h want %h", status_vec(), es);
                end
            end
            if (k == 9) begin
                es = exp_stat(ST_DONE, 9, 5, 1, 0, 9);
                n_cmp++;
                if (status_vec() !== es) begin
                    n_err++;
                    $display("[TB] FAIL trig_done: got %h want %h", status_vec(), es);
                end
            end
        end
        es = exp_stat(ST_DONE, 9, 5, 1, 0, 9);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL trig_after_done: got %h want %h", status_vec(), es);
        end
        issue_read(8);
        exp_r = {1'b1, exp_q.pop_front()};
        n_cmp++;
        if ({rd_valid, rd_err, rd_entry} !== exp_r) begin
            n_err++;
            $display("[TB] FAIL trig_read_last: got %h want %h", {rd_valid, rd_err, rd_entry}, exp_r);
        end
    endtask

    task automatic test_trigger_evict();
        logic [28:0] es;
        trig_en    = 1'b1;
        trig_op    = OP_JMP;
        post_count = 5'd17;
        do_arm();
        for (int k = 1; k <= 20; k++) begin
            do_retire(k - 1, (k == 3) ? OP_JMP : OP_ADD, 1'b1, 1'b0);
            if (k == 17) begin
                es = exp_stat(ST_POST, 16, 1, 1, 0, 17);
                n_cmp++;
                if (status_vec() !== es) begin
                    n_err++;
                    $display("[TB] FAIL evict_wrap_pos: got %h want %h", status_vec(), es);
                end
            end
        end
        es = exp_stat(ST_DONE, 16, 0, 1, 0, 20);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL evict_done: got %h want %h", status_vec(), es);
        end
    endtask

    task automatic test_trig_zero();
        logic [28:0] es;
        logic [22:0] exp_r;
        trig_en    = 1'b1;
        trig_op    = OP_STO;
        post_count = 5'd0;
        do_arm();
        do_retire(0, OP_ADD, 1'b1, 1'b0);
        do_retire(1, OP_ADD, 1'b1, 1'b0);
        do_retire(2, OP_STO, 1'b1, 1'b0);
        es = exp_stat(ST_DONE, 3, 2, 1, 0, 3);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL zero_post_done: got %h want %h", status_vec(), es);
        end
        do_retire(3, OP_STO, 1'b0, 1'b0);
        arm = 1'b1;
        do_retire(10, OP_ADD, 1'b0, 1'b0);
        arm = 1'b0;
        trace_q.delete();
        es = exp_stat(ST_ARMED, 0, 0, 0, 0, 0);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL rearm_clear: got %h want %h", status_vec(), es);
        end
        issue_read(0);
        exp_r = {1'b1, exp_q.pop_front()};
        n_cmp++;
        if ({rd_valid, rd_err, rd_entry} !== exp_r) begin
            n_err++;
            $display("[TB] FAIL empty_read_err: got %h want %h", {rd_valid, rd_err, rd_entry}, exp_r);
        end
        trig_en = 1'b0;
        arm = 1'b1;
        do_retire(11, OP_ADD, 1'b1, 1'b0);
        arm = 1'b0;
        es = exp_stat(ST_ARMED, 1, 0, 0, 0, 1);
        n_cmp++;
        if (status_vec() !== es) begin
            n_err++;
            $display("[TB] FAIL arm_ignored: got %h want %h", status_vec(), es);
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [28:0] es;
        trig_en    = 1'b1;
        trig_op    = OP_JMP;
        post_count = 5'd5;
        do_arm();
        do_retire(0, OP_JMP, 1'b1, 1'b0);
        do_retire(1, OP_ADD, 1'b1, 1'b0);
        rst    = 1'b1;
        rd_en  = 1'b1;
        rd_idx = 4'd0;
        do_retire(2, OP_ADD, 1'b0, 1'b0);
        rst   = 1'b0;
        rd_en = 1'b0;
        trace_q.delete();
        es = exp_stat(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({status_vec(), rd_valid, rd_err, rd_entry} !== {es, 23'h0}) begin
            n_err++;
            $display("[TB] FAIL mid_reset: got %h want %h", {status_vec(), rd_valid, rd_err, rd_entry}, {es, 23'h0});
        end
        do_retire(5, OP_ADD, 1'b0, 1'b0);
        n_cmp++;
        if ({status_vec(), rd_valid} !== {es, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL idle_retire: got %h want %h", {status_vec(), rd_valid}, {es, 1'b0});
        end
        trig_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [22:0] exp_r;
        trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 18; i++) do_retire(i, OP_ADD, 1'b1, 1'b0);
        push_read_exp(0);
        rd_en  = 1'b1;
        rd_idx = 4'd0;
        do_retire(20, OP_XOR, 1'b1, 1'b0);
        rd_en  = 1'b0;
        exp_r = {1'b1, exp_q.pop_front()};
        n_cmp++;
        if ({rd_valid, rd_err, rd_entry} !== exp_r) begin
            n_err++;
            $display("[TB] FAIL rw_same_slot: got %h want %h", {rd_valid, rd_err, rd_entry}, exp_r);
        end
        issue_read(0);
        exp_r = {1'b1, exp_q.pop_front()};
        n_cmp++;
        if ({rd_valid, rd_err, rd_entry} !== exp_r) begin
            n_err++;
            $display("[TB] FAIL b2b_read_0: got %h want %h", {rd_valid, rd_err, rd_entry}, exp_r);
        end
        issue_read(15);
        exp_r = {1'b1, exp_q.pop_front()};
        n_cmp++;
        if ({rd_valid, rd_err, rd_entry} !== exp_r) begin
            n_err++;
            $display("[TB] FAIL b2b_read_15: got %h want %h", {rd_valid, rd_err, rd_entry}, exp_r);
        end
        step();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rd_valid_pulse: got %b want 0", rd_valid);
        end
    endtask

    initial begin
        rst = 1'b1; retire = 1'b0; halt = 1'b0; arm = 1'b0; trig_en = 1'b0; rd_en = 1'b0;
        pc_addr = '0; ir_addr = '0; opcode = '0; data = '0; trig_op = '0; post_count = '0; rd_idx = '0;
        test_reset();
        test_halt_stop();
        test_wrap();
        test_trigger();
        test_trigger_evict();
        test_trig_zero();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
